// File: rtl/dma_pkg.sv
// Shared definitions for the dma_xfer block: FSM states, status bit indices, mode codes.
// Optional feature macro: DMA_XFER_ERR_ABORT_EN (abort transfer on ICB response error).
package dma_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRdCmd = 3'd1,
        StRdRsp = 3'd2,
        StWrCmd = 3'd3,
        StWrRsp = 3'd4,
        StDone  = 3'd5
    } dma_state_e;

    // Bit positions inside dma_ctr
    localparam int unsigned CtrBusy = 2;
    localparam int unsigned CtrDone = 1;
    localparam int unsigned CtrErr  = 0;

    // trans_matr[1:0] codes; anything else behaves as copy
    localparam logic [1:0] ModeCopy      = 2'b00;
    localparam logic [1:0] ModeTranspose = 2'b01;

    localparam logic [31:0] WordBytes = 32'd4;

    // States in which a transfer is in flight
    function automatic logic is_busy_state(input dma_state_e s);
        return (s == StRdCmd) || (s == StRdRsp) || (s == StWrCmd) || (s == StWrRsp);
    endfunction

endpackage

// File: rtl/dma_xfer_if.sv
// ICB master bus (command + response channels) used by dma_xfer.
interface dma_xfer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/dma_addr_gen.sv
// Element counters and running source/destination pointers for dma_xfer.
// Pointers advance by additions only; all arithmetic wraps modulo 2^32.
module dma_addr_gen
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] sour_addr,
    input  logic [31:0] dest_addr,
    input  logic [31:0] line_size,
    input  logic [31:0] row_size,
    input  logic        transpose,
    output logic [31:0] src_ptr,
    output logic [31:0] dst_ptr,
    output logic        last
);

    logic [31:0] line_q;
    logic [31:0] rows_q;
    logic        transpose_q;
    logic [31:0] col_cnt_q;
    logic [31:0] row_cnt_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] dst_row_q;   // destination of column 0 in the current row (transpose)
    logic        col_end;
    logic        row_end;
    logic [31:0] col_stride;

    assign col_end    = (col_cnt_q == line_q - 32'd1);
    assign row_end    = (row_cnt_q == rows_q - 32'd1);
    assign last       = col_end && row_end;
    assign col_stride = transpose_q ? {rows_q[29:0], 2'b00} : WordBytes;
    assign src_ptr    = src_q;
    assign dst_ptr    = dst_q;

    // Snapshot on load; step to the next row-major element on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q      <= '0;
            rows_q      <= '0;
            transpose_q <= 1'b0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            dst_row_q   <= '0;
        end else if (load) begin
            line_q      <= line_size;
            rows_q      <= row_size;
            transpose_q <= transpose;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            src_q       <= sour_addr;
            dst_q       <= dest_addr;
            dst_row_q   <= dest_addr;
        end else if (advance) begin
            // Source is contiguous in row-major order in both modes
            src_q <= src_q + WordBytes;
            if (col_end) begin
                col_cnt_q <= '0;
                row_cnt_q <= row_cnt_q + 32'd1;
                dst_row_q <= dst_row_q + WordBytes;
                dst_q     <= transpose_q ? dst_row_q + WordBytes : dst_q + WordBytes;
            end else begin
                col_cnt_q <= col_cnt_q + 32'd1;
                dst_q     <= dst_q + col_stride;
            end
        end
    end

endmodule

// File: rtl/dma_xfer.sv
// Single-channel DMA: copies or transposes a row_size x line_size matrix of 32-bit words
// over an ICB master port, one outstanding transaction at a time.
// Optional feature macro: DMA_XFER_ERR_ABORT_EN -- when defined, an ICB response error
// aborts the transfer and sets the sticky error flag; otherwise rsp_err is ignored.
module dma_xfer
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       sour_addr,
    input  logic [31:0]       dest_addr,
    input  logic [31:0]       line_size,
    input  logic [31:0]       row_size,
    input  logic [31:0]       trans_matr,
    input  logic              cfg_vld,
    output logic [2:0]        dma_ctr,
    dma_xfer_if.master        dma_icb
);

    dma_state_e  state_q, state_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] data_q;
    logic        start;
    logic        zero_len;
    logic        advance;
    logic        transpose;
    logic        err_abort;
    logic [31:0] src_ptr;
    logic [31:0] dst_ptr;
    logic        last;
    logic        unused_mode;

    assign start       = (state_q == StIdle) && cfg_vld;
    assign zero_len    = (line_size == 32'd0) || (row_size == 32'd0);
    assign advance     = (state_q == StWrRsp) && dma_icb.rsp_valid;
    assign unused_mode = ^trans_matr[31:2];

`ifdef DMA_XFER_ERR_ABORT_EN
    assign err_abort = dma_icb.rsp_valid && dma_icb.rsp_err;
`else
    logic unused_rsp_err;
    assign unused_rsp_err = dma_icb.rsp_err;
    assign err_abort      = 1'b0;
`endif

    // Decode the mode field; unknown codes fall back to copy
    always_comb begin
        transpose = 1'b0;
        case (trans_matr[1:0])
            ModeCopy:      transpose = 1'b0;
            ModeTranspose: transpose = 1'b1;
            default:       transpose = 1'b0;
        endcase
    end

    dma_addr_gen u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start),
        .advance   (advance),
        .sour_addr (sour_addr),
        .dest_addr (dest_addr),
        .line_size (line_size),
        .row_size  (row_size),
        .transpose (transpose),
        .src_ptr   (src_ptr),
        .dst_ptr   (dst_ptr),
        .last      (last)
    );

    // State and sticky status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Read data buffer, filled by the read response of the current element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if ((state_q == StRdRsp) && dma_icb.rsp_valid) begin
            data_q <= dma_icb.rsp_rdata;
        end
    end

    // Next-state and status update
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_vld) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = zero_len ? StDone : StRdCmd;
                end
            end
            StRdCmd: begin
                if (dma_icb.cmd_ready) state_d = StRdRsp;
            end
            StRdRsp: begin
                if (dma_icb.rsp_valid) begin
                    if (err_abort) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWrCmd;
                    end
                end
            end
            StWrCmd: begin
                if (dma_icb.cmd_ready) state_d = StWrRsp;
            end
            StWrRsp: begin
                if (dma_icb.rsp_valid) begin
                    if (err_abort) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = last ? StDone : StRdCmd;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // done becomes visible in the DONE cycle itself
        if (state_d == StDone) done_d = 1'b1;
    end

    // ICB command fields derive from state and pointers, so they hold while stalled
    always_comb begin
        dma_icb.cmd_valid = 1'b0;
        dma_icb.cmd_read  = 1'b0;
        dma_icb.cmd_addr  = '0;
        dma_icb.cmd_wdata = '0;
        dma_icb.cmd_wmask = '0;
        dma_icb.rsp_ready = 1'b1;
        if (state_q == StRdCmd) begin
            dma_icb.cmd_valid = 1'b1;
            dma_icb.cmd_read  = 1'b1;
            dma_icb.cmd_addr  = src_ptr;
        end else if (state_q == StWrCmd) begin
            dma_icb.cmd_valid = 1'b1;
            dma_icb.cmd_addr  = dst_ptr;
            dma_icb.cmd_wdata = data_q;
            dma_icb.cmd_wmask = 4'hF;
        end
    end

    // Status word
    always_comb begin
        dma_ctr          = '0;
        dma_ctr[CtrBusy] = is_busy_state(state_q);
        dma_ctr[CtrDone] = done_q;
`ifdef DMA_XFER_ERR_ABORT_EN
        dma_ctr[CtrErr]  = err_q;
`else
        dma_ctr[CtrErr]  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dma_xfer.sv
// Scoreboard bench for dma_xfer: a reference model expands each configuration into the
// expected ICB command list; a randomized slave records commands, a monitor compares.
`timescale 1ns/1ps
module tb_dma_xfer;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sour_addr, dest_addr, line_size, row_size, trans_matr;
    logic        cfg_vld;
    logic [2:0]  dma_ctr;

    int chk_cnt = 0;
    int err_cnt = 0;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    cmd_t mon_o, mon_e;

    logic [31:0] data_seed = 32'h1234_5678;
    int err_idx     = -1;
    int rd_count    = 0;
    int force_stall = 0;
    int wr_stall    = 0;
    bit rand_delay  = 1'b0;

    // slave bookkeeping
    bit          hs_pend, rsp_pend, stall_active, rsp_is_read;
    int          stall_left, rsp_wait;
    cmd_t        cap, prev;
    logic [31:0] rsp_addr;

    always #5 clk = ~clk;

    dma_xfer_if bus ();

    dma_xfer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sour_addr  (sour_addr),
        .dest_addr  (dest_addr),
        .line_size  (line_size),
        .row_size   (row_size),
        .trans_matr (trans_matr),
        .cfg_vld    (cfg_vld),
        .dma_ctr    (dma_ctr),
        .dma_icb    (bus)
    );

    function automatic logic [31:0] rd_fun(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ data_seed;
    endfunction

    function automatic cmd_t cur_cmd();
        cmd_t t;
        t.addr  = bus.cmd_addr;
        t.read  = bus.cmd_read;
        t.wdata = bus.cmd_wdata;
        t.wmask = bus.cmd_wmask;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: element (r,c) read from sa+4(r*L+c), written to the mode's destination
    task automatic model(input logic [31:0] sa, input logic [31:0] da, input logic [31:0] ls,
                         input logic [31:0] rs, input logic [31:0] tm, input int eidx);
        logic [31:0] s, d;
        cmd_t t;
        int n;
        n = 0;
        for (int r = 0; r < int'(rs); r++) begin
            for (int c = 0; c < int'(ls); c++) begin
                s = sa + 32'd4 * (32'(r) * ls + 32'(c));
                if (tm[1:0] == 2'b01) d = da + 32'd4 * (32'(c) * rs + 32'(r));
                else                  d = da + 32'd4 * (32'(r) * ls + 32'(c));
                t = '{addr: s, read: 1'b1, wdata: 32'd0, wmask: 4'd0};
                exp_q.push_back(t);
`ifdef DMA_XFER_ERR_ABORT_EN
                if (n == eidx) return;
`endif
                t = '{addr: d, read: 1'b0, wdata: rd_fun(s), wmask: 4'hF};
                exp_q.push_back(t);
                n++;
            end
        end
    endtask

    // ICB slave: random cmd_ready stalls and response latency, commands logged to obs_q
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.cmd_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_err   = 1'b0;
            bus.rsp_rdata = '0;
            hs_pend       = 1'b0;
            rsp_pend      = 1'b0;
            stall_active  = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                bus.rsp_valid = 1'b0;
                bus.rsp_err   = 1'b0;
            end
            if (hs_pend) begin
                obs_q.push_back(cap);
                hs_pend      = 1'b0;
                stall_active = 1'b0;
                rsp_pend     = 1'b1;
                rsp_is_read  = cap.read;
                rsp_addr     = cap.addr;
                rsp_wait     = rand_delay ? int'($urandom_range(0, 2)) : 0;
            end
            if (rsp_pend) check("one_outstanding", {31'd0, bus.cmd_valid}, 32'd0);
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    bus.rsp_valid = 1'b1;
                    check("rsp_ready_high", {31'd0, bus.rsp_ready}, 32'd1);
                    if (rsp_is_read) begin
                        bus.rsp_rdata = rd_fun(rsp_addr);
                        bus.rsp_err   = (rd_count == err_idx);
                        rd_count++;
                    end else begin
                        bus.rsp_rdata = $urandom;
                        bus.rsp_err   = 1'b0;
                    end
                    rsp_pend = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            if (stall_active) begin
                check("cmd_valid_hold", {31'd0, bus.cmd_valid}, 32'd1);
                if (bus.cmd_valid) begin
                    check("stable_addr", bus.cmd_addr, prev.addr);
                    check("stable_read", {31'd0, bus.cmd_read}, {31'd0, prev.read});
                    check("stable_wdata", bus.cmd_wdata, prev.wdata);
                    check("stable_wmask", {28'd0, bus.cmd_wmask}, {28'd0, prev.wmask});
                end
            end
            if (bus.cmd_valid) begin
                if (!stall_active) begin
                    stall_active = 1'b1;
                    prev         = cur_cmd();
                    if (force_stall > 0) begin
                        stall_left  = force_stall;
                        force_stall = 0;
                    end else if (!bus.cmd_read && wr_stall > 0) begin
                        stall_left = wr_stall;
                    end else begin
                        stall_left = rand_delay ? int'($urandom_range(0, 3)) : 0;
                    end
                end
                if (stall_left == 0) begin
                    bus.cmd_ready = 1'b1;
                    hs_pend       = 1'b1;
                    cap           = cur_cmd();
                end else begin
                    bus.cmd_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                bus.cmd_ready = 1'b0;
                stall_active  = 1'b0;
            end
        end
    end

    // Monitor: compare every accepted command against the scoreboard head
    always begin
        @(negedge clk);
        #1;
        while (obs_q.size() > 0) begin
            mon_o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                chk_cnt++;
                err_cnt++;
                $display("FAIL unexpected_cmd: got addr 0x%08h read %0d, expected no command",
                         mon_o.addr, mon_o.read);
            end else begin
                mon_e = exp_q.pop_front();
                check("cmd_addr", mon_o.addr, mon_e.addr);
                check("cmd_read", {31'd0, mon_o.read}, {31'd0, mon_e.read});
                if (!mon_e.read) begin
                    check("cmd_wdata", mon_o.wdata, mon_e.wdata);
                    check("cmd_wmask", {28'd0, mon_o.wmask}, {28'd0, mon_e.wmask});
                end
            end
        end
    end

    task automatic start_xfer(input logic [31:0] sa, input logic [31:0] da,
                              input logic [31:0] ls, input logic [31:0] rs,
                              input logic [31:0] tm, input int eidx);
        data_seed = $urandom;
        err_idx   = eidx;
        rd_count  = 0;
        model(sa, da, ls, rs, tm, eidx);
        @(negedge clk);
        sour_addr  = sa;
        dest_addr  = da;
        line_size  = ls;
        row_size   = rs;
        trans_matr = tm;
        cfg_vld    = 1'b1;
        @(negedge clk);
        cfg_vld    = 1'b0;
    endtask

    task automatic wait_xfer(input string tag, input logic [2:0] first_ctr,
                             input logic [2:0] final_ctr, input int budget, output int cyc);
        check({tag, "_start_ctr"}, {29'd0, dma_ctr}, {29'd0, first_ctr});
        cyc = 1;
        while (!(dma_ctr[1] && !dma_ctr[2]) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!(dma_ctr[1] && !dma_ctr[2])) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL %s_timeout: dma_ctr 0x%0h after %0d cycles, expected done", tag,
                     dma_ctr, cyc);
        end
        check({tag, "_final_ctr"}, {29'd0, dma_ctr}, {29'd0, final_ctr});
        repeat (2) @(negedge clk);
        #2;
        check({tag, "_drained"}, exp_q.size(), 32'd0);
        check({tag, "_sticky_ctr"}, {29'd0, dma_ctr}, {29'd0, final_ctr});
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [2:0]  err_ctr;
        int          found;
        logic [31:0] ls, rs, sa, da, tm;

        rst_n      = 1'b0;
        sour_addr  = '0;
        dest_addr  = '0;
        line_size  = '0;
        row_size   = '0;
        trans_matr = '0;
        cfg_vld    = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;

        repeat (3) @(negedge clk);
        check("rst_dma_ctr", {29'd0, dma_ctr}, 32'd0);
        check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("rst_cmd_addr", bus.cmd_addr, 32'd0);
        check("rst_cmd_read", {31'd0, bus.cmd_read}, 32'd0);
        check("rst_cmd_wdata", bus.cmd_wdata, 32'd0);
        check("rst_cmd_wmask", {28'd0, bus.cmd_wmask}, 32'd0);
        #2 rst_n = 1'b1;

        // Degenerate sizes: straight to done, no bus traffic
        start_xfer(32'h1000_0000, 32'h2000_0000, 32'd0, 32'd3, 32'd0, -1);
        wait_xfer("zero_line", 3'b010, 3'b010, 4, cyc);
        check("zero_line_latency", {31'd0, cyc <= 2}, 32'd1);
        start_xfer(32'h1000_0000, 32'h2000_0000, 32'd3, 32'd0, 32'd1, -1);
        wait_xfer("zero_row", 3'b010, 3'b010, 4, cyc);

        // Copy 2x3, zero-wait slave
        start_xfer(32'h2000_0000, 32'h2000_0100, 32'd3, 32'd2, 32'd0, -1);
        wait_xfer("copy", 3'b100, 3'b010, 200, cyc);
        check("copy_min_cycles", {31'd0, cyc >= 24}, 32'd1);

        // Transpose 2 rows x 3 columns
        start_xfer(32'h1000_0040, 32'h3000_0000, 32'd3, 32'd2, 32'd1, -1);
        wait_xfer("transpose", 3'b100, 3'b010, 200, cyc);

        // 5-cycle stall on the first read with a cfg_vld pulse that must be ignored
        force_stall = 5;
        start_xfer(32'h4000_0000, 32'h5000_0000, 32'd2, 32'd2, 32'd0, -1);
        @(negedge clk);
        sour_addr  = 32'h7000_0000;
        dest_addr  = 32'h7100_0000;
        line_size  = 32'd0;
        row_size   = 32'd1;
        trans_matr = 32'd1;
        cfg_vld    = 1'b1;
        @(negedge clk);
        cfg_vld    = 1'b0;
        wait_xfer("stall", 3'b100, 3'b010, 200, cyc);

        // Error on the second read
`ifdef DMA_XFER_ERR_ABORT_EN
        err_ctr = 3'b011;
`else
        err_ctr = 3'b010;
`endif
        start_xfer(32'h6000_0000, 32'h6100_0000, 32'd2, 32'd2, 32'd0, 1);
        wait_xfer("rsp_err", 3'b100, err_ctr, 300, cyc);

        // Randomized configurations with random stalls and response latency
        rand_delay = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ls = 32'($urandom_range(1, 4));
            rs = 32'($urandom_range(1, 4));
            sa = $urandom & 32'hFFFF_FFFC;
            da = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 2) == 0) sa = 32'hFFFF_FFF0;
            if ($urandom_range(0, 2) == 0) da = 32'hFFFF_FFF8;
            tm = $urandom;
            start_xfer(sa, da, ls, rs, tm, -1);
            wait_xfer("random", 3'b100, 3'b010, 40 * int'(ls * rs) + 20, cyc);
        end
        rand_delay = 1'b0;

        // Reset while a write command is stalled
        wr_stall = 20;
        start_xfer(32'h0800_0000, 32'h0900_0000, 32'd2, 32'd2, 32'd0, -1);
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            if (bus.cmd_valid && !bus.cmd_read) found = 1;
            else @(negedge clk);
        end
        check("reach_wr_cmd", found, 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_dma_ctr", {29'd0, dma_ctr}, 32'd0);
        check("midrst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("midrst_cmd_addr", bus.cmd_addr, 32'd0);
        exp_q.delete();
        obs_q.delete();
        wr_stall = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("postrst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("postrst_dma_ctr", {29'd0, dma_ctr}, 32'd0);

        // Fresh transfer after reset; source pointer wraps past 0xFFFF_FFFC
        start_xfer(32'hFFFF_FFFC, 32'h0000_0100, 32'd2, 32'd2, 32'd0, -1);
        wait_xfer("wrap", 3'b100, 3'b010, 200, cyc);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dma_xfer.md
DMA_XFER -- requirements
Module: dma_xfer

Interface
REQ-001 clk  input  1  block clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 sour_addr  input  32  source base byte address.
REQ-004 dest_addr  input  32  destination base byte address.
REQ-005 line_size  input  32  words per row (columns).
REQ-006 row_size  input  32  number of rows.
REQ-007 trans_matr  input  32  mode; [1:0]=00 copy, 01 transpose, others treated as copy; [31:2] ignored.
REQ-008 cfg_vld  input  1  one-cycle start pulse.
REQ-009 dma_ctr  output  3  status: [2] busy, [1] done (sticky), [0] error (sticky).
REQ-010 dma_icb_cmd_valid/ready/addr/read/wdata/wmask  out/in/out/out/out/out  1/1/32/1/32/4  ICB master command channel.
REQ-011 dma_icb_rsp_valid/ready/err/rdata  in/out/in/in  1/1/1/32  ICB master response channel.

Function
REQ-012 Transfer unit: one 32-bit word per element; element (r,c) has source address sour_addr + 4*(r*line_size + c).
REQ-013 Destination of (r,c): copy = dest_addr + 4*(r*line_size + c); transpose = dest_addr + 4*(c*row_size + r).
REQ-014 Addresses: running pointers, no multipliers; all sums modulo 2^32 (wrap silently).
REQ-015 Element order: row-major; c from 0 to line_size-1, then r increments.
REQ-016 FSM states: IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, DONE.
REQ-017 IDLE: cfg_vld=1 snapshots all config inputs; next cycle RD_CMD, busy=1, done=0, error=0.
REQ-018 cfg_vld while busy: ignored; the snapshot is unchanged.
REQ-019 line_size==0 or row_size==0 at start: IDLE->DONE directly, no bus command issued.
REQ-020 RD_CMD: cmd_valid=1, read=1, addr=source pointer; on valid&ready -> RD_RSP.
REQ-021 RD_RSP: on rsp_valid, capture rdata into data buffer -> WR_CMD.
REQ-022 WR_CMD: cmd_valid=1, read=0, addr=dest pointer, wdata=buffer, wmask=4'hF; on valid&ready -> WR_RSP.
REQ-023 WR_RSP: on rsp_valid; last element -> DONE, else advance pointers/counters -> RD_CMD.
REQ-024 DONE: lasts one cycle; busy=0, done=1 -> IDLE.
REQ-025 At most one outstanding transaction; cmd_addr/read/wdata/wmask stable while cmd_valid=1 and ready=0.
REQ-026 cmd_valid never deasserts without handshake; dma_icb_rsp_ready is constant 1.
REQ-027 Minimum cost per element: 4 cycles with zero-wait slave (cmd, rsp, cmd, rsp).
REQ-028 done and error persist in IDLE until the next accepted cfg_vld.

Reset
REQ-029 Reset values: state IDLE, dma_ctr=3'b000, cmd_valid=0, cmd_addr=0, cmd_read=0, cmd_wdata=0, cmd_wmask=0, counters/pointers/buffer=0.
REQ-030 Reset mid-transfer: the transfer is abandoned immediately; no command is pending after reset release.

Configuration
REQ-031 Macro DMA_XFER_ERR_ABORT_EN defined: rsp_err=1 with rsp_valid in RD_RSP/WR_RSP sets error, skips the remaining elements, goes to DONE (done=1, error=1).
REQ-032 Macro DMA_XFER_ERR_ABORT_EN undefined: rsp_err is ignored, the transfer runs to completion, dma_ctr[0] is constant 0.

Structure
REQ-033 Shared package dma_pkg holds: FSM state encodings, dma_ctr bit indices (BUSY=2, DONE=1, ERR=0), mode codes (COPY=2'b00, TRANSPOSE=2'b01).
REQ-034 One sub-module dma_addr_gen contains the counters and the source/destination pointer update (row/column wrap, transpose stride 4*row_size); dma_xfer holds the FSM and the ICB signalling.

Verification
REQ-035 Copy 2x3 from 0x2000_0000 to 0x2000_0100, zero-wait slave -> 6 reads at 0x...00..0x...14 ascending, 6 writes in the same order, done after 24+ cycles.
REQ-036 Transpose row_size=2, line_size=3, dest 0x3000_0000 -> write sequence 0x00,0x08,0x10,0x04,0x0C,0x14 with data matching the reads.
REQ-037 Slave holds cmd_ready=0 for 5 cycles -> cmd fields stable throughout; cfg_vld pulse at the same time -> ignored.
REQ-038 line_size=0 -> no cmd_valid; dma_ctr goes 3'b000 -> 3'b010 in 2 cycles.
REQ-039 DMA_XFER_ERR_ABORT_EN defined, rsp_err on 2nd read -> no further commands; dma_ctr=3'b011. Undefined -> all elements transferred; dma_ctr=3'b010.
REQ-040 rst_n low during WR_CMD, then high -> cmd_valid=0, dma_ctr=0; a new cfg_vld runs correctly; source address 0xFFFF_FFFC wraps to 0x0000_0000.
